cpu_fetch: RTL and testbench
============================

# cpu_fetch

Instruction fetch stage for the enhanced 65C02-compatible `cpu`. It reads the reset vector, then fetches opcode and operand bytes over a byte-wide memory read port. It determines each instruction's length from its opcode and presents a packed 32-bit instruction word to the decode stage, which loads it into its instruction register. A valid/ready handshake connects it to decode, and a redirect input from execute flushes fetch for jumps, branches, returns and interrupts.

## Interface
- `RESET_VECTOR`, default 32'h0000FFFC: byte address of the reset vector low byte; the high byte is at `RESET_VECTOR+1`.
- `i_clk` in 1: clock. One clock domain.
- `i_rst` in 1: reset, synchronous, active-high.
- `o_mem_req` in→out 1: read request.
- `o_mem_addr` out 32: read byte address; valid while `o_mem_req`=1.
- `i_mem_ack` in 1: transfer completes in the cycle where `o_mem_req`=1 and `i_mem_ack`=1.
- `i_mem_data` in 8: read data; valid in the ack cycle.
- `o_ir_valid` out 1: instruction word available.
- `o_ir` out 32: IR0=[7:0] opcode, IR1=[15:8], IR2=[23:16], IR3=[31:24]=0. Bytes not fetched are 0.
- `o_ir_pc` out 32: address of the opcode byte.
- `o_ir_len` out 2: instruction length, 1 to 3.
- `i_ir_ready` in 1: decode accepts the word when `o_ir_valid`=1 and `i_ir_ready`=1.
- `i_redirect` in 1: flush and restart at `i_redirect_pc`.
- `i_redirect_pc` in 32: new fetch address.

## Operation
- **States:** BOOT, VEC_LO, VEC_HI, OPCODE, OPND1, OPND2, HOLD.
- **Memory request:** `o_mem_req`=1 only in VEC_LO, VEC_HI, OPCODE, OPND1 and OPND2.
- **Request withdrawal:** memory must tolerate withdrawal of a request without ack. Fetch never waits for an ack it has abandoned.
- **Reset:** state=BOOT, PC=0, `o_mem_req`=0, `o_ir_valid`=0, `o_ir`=0, `o_ir_pc`=0, `o_ir_len`=0.
- **BOOT:** moves to VEC_LO unconditionally.
- **VEC_LO:** reads address `RESET_VECTOR`.
- **VEC_HI:** reads address `RESET_VECTOR+1`. On ack, PC={16'h0, hi, lo} and state moves to OPCODE.
- **Redirect during boot:** ignored in BOOT, VEC_LO and VEC_HI.
- **OPCODE:** address=PC. On ack, latch the opcode, set `o_ir_pc`=PC, PC+=1, and look up the length.
  - Length 1: move to HOLD.
  - Otherwise: move to OPND1.
- **OPND1 / OPND2:** address=PC. On ack, latch IR1 or IR2 and PC+=1. Move to HOLD once all bytes are fetched.
- **HOLD:** `o_ir_valid`=1. `o_ir`, `o_ir_pc` and `o_ir_len` stay stable until the handshake. On handshake, move to OPCODE.
- **PC arithmetic:** 32-bit, wraps from FFFFFFFF to 00000000.
- **Length rule, by opcode low nibble:**
  - x0: 20→3; 40 and 60→1; all others, including BRK 00, →2.
  - x1, x2, x4, x5, x6, x7: 2.
  - x3, x8, xA, xB: 1.
  - x9: 3 when the high nibble is odd, 2 when it is even (immediate).
  - xC, xD, xE, xF: 3. BBR/BBS (xF) is zp plus rel.
- **Redirect (OPCODE through HOLD):** highest priority after reset. Next cycle: PC=`i_redirect_pc`, `o_ir_valid`=0, state=OPCODE.
  - Data acked in the redirect cycle is discarded.
  - A word handshaken in the redirect cycle counts as consumed.

## Timing
- **Zero-wait 1-byte instruction:** opcode ack in cycle T, `o_ir_valid`=1 in T+1.
- **Zero-wait 2-byte and 3-byte instructions:** `o_ir_valid`=1 in T+2 and T+3 respectively.
- **After handshake:** handshake in cycle H gives an OPCODE request in H+1. There is no prefetch, so peak throughput is one 1-byte instruction per 2 cycles.
- **Wait states:** each wait cycle (req=1, ack=0) holds state and address unchanged.
- **Reset release:** reset released before cycle 0 gives:
  - cycle 0: BOOT
  - cycle 1: VEC_LO request
  - cycle 2: VEC_HI request (zero-wait)
  - cycle 3: first OPCODE request
- **Reset mid-operation:** overrides everything in the same edge and returns to BOOT. It overrides handshakes, redirects and acks.

## Structure
- **Package `cpu_pkg`:** shared by `cpu` and `cpu_fetch`. Holds:
  - the `DataWidth`, `AddressMode` and `Operation` enums;
  - the `FetchState` enum;
  - the `RESET_VECTOR` default;
  - a function `op_length(opcode)` returning 2 bits.
- **Sub-modules:** none. The length lookup is the package function. Operand-byte steering is inline, in a single always block plus combinational address/request logic.

## Test plan
- **Reset vector:** mem[FFFC]=00, mem[FFFD]=80, zero-wait → cycle 3 after release: req=1, addr=00008000.
- **Length decode:** bytes A9 42 8D 00 02 EA at 8000, ready=1 → words in order:
  - 000042A9, len2, pc 8000
  - 0002008D, len3, pc 8002
  - 000000EA, len1, pc 8005
- **BBR:** 0F 12 FE at 9000 → `o_ir`=00FE120F, len3; the next opcode request goes to 9003.
- **Backpressure:** ready=0 for 5 cycles in HOLD → valid held at 1, `o_ir` stable, req=0. Ready=1 → OPCODE request the next cycle.
- **Redirect mid-instruction:** in OPND1 with ack=0, pulse redirect to 00001234 → next cycle req=1, addr=00001234. The partial instruction is never presented.
- **Wrap and wait states:** PC=FFFFFFFF, opcode EA with 2 wait cycles → valid 1 cycle after ack, pc FFFFFFFF; the next request goes to 00000000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and helpers for the 65C02-compatible cpu and its fetch stage.
package cpu_pkg;

  // Byte address of the reset vector low byte; the high byte follows it.
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_FFFC;

  localparam int ADDR_W = 32;
  localparam int BYTE_W = 8;
  localparam int IR_W   = 32;

  // Operand size of an operation.
  typedef enum logic [0:0] {
    DW_8,
    DW_16
  } DataWidth;

  // Addressing modes of the enhanced 65C02 instruction set.
  typedef enum logic [3:0] {
    AM_IMP,
    AM_ACC,
    AM_IMM,
    AM_ZP,
    AM_ZPX,
    AM_ZPY,
    AM_ZPI,
    AM_ABS,
    AM_ABSX,
    AM_ABSY,
    AM_IND,
    AM_INDX,
    AM_INDY,
    AM_ABSXI,
    AM_REL,
    AM_ZPREL
  } AddressMode;

  // Operations decoded from the opcode.
  typedef enum logic [6:0] {
    OP_ADC, OP_AND, OP_ASL, OP_BBR, OP_BBS, OP_BCC, OP_BCS, OP_BEQ,
    OP_BIT, OP_BMI, OP_BNE, OP_BPL, OP_BRA, OP_BRK, OP_BVC, OP_BVS,
    OP_CLC, OP_CLD, OP_CLI, OP_CLV, OP_CMP, OP_CPX, OP_CPY, OP_DEC,
    OP_DEX, OP_DEY, OP_EOR, OP_INC, OP_INX, OP_INY, OP_JMP, OP_JSR,
    OP_LDA, OP_LDX, OP_LDY, OP_LSR, OP_NOP, OP_ORA, OP_PHA, OP_PHP,
    OP_PHX, OP_PHY, OP_PLA, OP_PLP, OP_PLX, OP_PLY, OP_RMB, OP_ROL,
    OP_ROR, OP_RTI, OP_RTS, OP_SBC, OP_SEC, OP_SED, OP_SEI, OP_SMB,
    OP_STA, OP_STP, OP_STX, OP_STY, OP_STZ, OP_TAX, OP_TAY, OP_TRB,
    OP_TSB, OP_TSX, OP_TXA, OP_TXS, OP_TYA, OP_WAI
  } Operation;

  // Fetch stage sequencing.
  typedef enum logic [2:0] {
    FS_BOOT,
    FS_VEC_LO,
    FS_VEC_HI,
    FS_OPCODE,
    FS_OPND1,
    FS_OPND2,
    FS_HOLD
  } FetchState;

  // Instruction length in bytes (1..3), decided by the opcode alone.
  function automatic logic [1:0] op_length(input logic [7:0] opcode);
    logic [1:0] len;
    len = 2'd2;
    case (opcode[3:0])
      4'h0: begin
        if (opcode == 8'h20)
          len = 2'd3;                                  // JSR abs
        else if (opcode == 8'h40 || opcode == 8'h60)
          len = 2'd1;                                  // RTI, RTS
        else
          len = 2'd2;                                  // BRK, branches, immediates
      end
      4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7: len = 2'd2;
      4'h3, 4'h8, 4'hA, 4'hB:             len = 2'd1;
      4'h9:                               len = opcode[4] ? 2'd3 : 2'd2;  // abs,Y vs immediate
      4'hC, 4'hD, 4'hE, 4'hF:             len = 2'd3;  // xF is BBR/BBS zp,rel
      default:                            len = 2'd2;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: reads the reset vector, then fetches opcode and
// operand bytes over a byte-wide read port and hands a packed 32-bit word to
// decode with a valid/ready handshake. Execute can redirect fetch at any time
// after boot.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_data,
  output logic        o_ir_valid,
  output logic [31:0] o_ir,
  output logic [31:0] o_ir_pc,
  output logic [1:0]  o_ir_len,
  input  logic        i_ir_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  FetchState   state;
  logic [31:0] pc;
  logic [7:0]  vec_lo;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [1:0]  ir_len;

  logic        mem_xfer;
  logic        ir_xfer;
  logic        redirect_act;
  logic [1:0]  opcode_len;

  // Request is raised only in the reading states; the address comes from the
  // vector location during boot and from the PC afterwards.
  always_comb begin
    o_mem_req  = 1'b0;
    o_mem_addr = pc;
    case (state)
      FS_VEC_LO: begin
        o_mem_req  = 1'b1;
        o_mem_addr = RESET_VECTOR;
      end
      FS_VEC_HI: begin
        o_mem_req  = 1'b1;
        o_mem_addr = RESET_VECTOR + 32'd1;
      end
      FS_OPCODE, FS_OPND1, FS_OPND2: begin
        o_mem_req  = 1'b1;
        o_mem_addr = pc;
      end
      default: begin
        o_mem_req  = 1'b0;
        o_mem_addr = pc;
      end
    endcase
  end

  assign mem_xfer     = o_mem_req & i_mem_ack;
  assign ir_xfer      = ir_valid & i_ir_ready;
  // Redirects are meaningless before the vector has been read.
  assign redirect_act = i_redirect &
                        ((state == FS_OPCODE) || (state == FS_OPND1) ||
                         (state == FS_OPND2)  || (state == FS_HOLD));
  assign opcode_len   = op_length(i_mem_data);

  // Low vector byte is only a staging value for the PC load; no reset needed.
  always_ff @(posedge i_clk) begin
    if (state == FS_VEC_LO && mem_xfer)
      vec_lo <= i_mem_data;
  end

  // Fetch sequencer: reset beats redirect, redirect beats acks and handshakes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= FS_BOOT;
      pc       <= 32'h0;
      ir_valid <= 1'b0;
      ir       <= 32'h0;
      ir_pc    <= 32'h0;
      ir_len   <= 2'd0;
    end else if (redirect_act) begin
      // Any in-flight ack is dropped and a handshake this cycle still consumes.
      state    <= FS_OPCODE;
      pc       <= i_redirect_pc;
      ir_valid <= 1'b0;
    end else begin
      case (state)
        FS_BOOT: begin
          state <= FS_VEC_LO;
        end
        FS_VEC_LO: begin
          if (mem_xfer)
            state <= FS_VEC_HI;
        end
        FS_VEC_HI: begin
          if (mem_xfer) begin
            pc    <= {16'h0, i_mem_data, vec_lo};
            state <= FS_OPCODE;
          end
        end
        FS_OPCODE: begin
          if (mem_xfer) begin
            // Unfetched operand bytes must read back as zero.
            ir     <= {24'h0, i_mem_data};
            ir_pc  <= pc;
            ir_len <= opcode_len;
            pc     <= pc + 32'd1;
            if (opcode_len == 2'd1) begin
              ir_valid <= 1'b1;
              state    <= FS_HOLD;
            end else begin
              state <= FS_OPND1;
            end
          end
        end
        FS_OPND1: begin
          if (mem_xfer) begin
            ir[15:8] <= i_mem_data;
            pc       <= pc + 32'd1;
            if (ir_len == 2'd2) begin
              ir_valid <= 1'b1;
              state    <= FS_HOLD;
            end else begin
              state <= FS_OPND2;
            end
          end
        end
        FS_OPND2: begin
          if (mem_xfer) begin
            ir[23:16] <= i_mem_data;
            pc        <= pc + 32'd1;
            ir_valid  <= 1'b1;
            state     <= FS_HOLD;
          end
        end
        FS_HOLD: begin
          // No prefetch: the next opcode is requested only after decode takes this word.
          if (ir_xfer) begin
            ir_valid <= 1'b0;
            state    <= FS_OPCODE;
          end
        end
        default: begin
          state <= FS_BOOT;
        end
      endcase
    end
  end

  assign o_ir_valid = ir_valid;
  assign o_ir       = ir;
  assign o_ir_pc    = ir_pc;
  assign o_ir_len   = ir_len;

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: boot vector, length decode, BBR, backpressure,
// redirects, PC wrap with wait states and mid-operation reset.
module tb_cpu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [1:0]  ir_len;
  logic        ir_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        ack_en;
  int          wait_cfg;
  int          wcnt;
  int          n_vec = 0;
  int          n_err = 0;
  int          lat;

  always #5 clk = ~clk;

  cpu_fetch #(
    .RESET_VECTOR(32'h0000_FFFC)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_ack    (mem_ack),
    .i_mem_data   (mem_data),
    .o_ir_valid   (ir_valid),
    .o_ir         (ir),
    .o_ir_pc      (ir_pc),
    .o_ir_len     (ir_len),
    .i_ir_ready   (ir_ready),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc)
  );

  // Static program image; unlisted bytes read as 00.
  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_FFFC: return 8'h00;
      32'h0000_FFFD: return 8'h80;
      32'h0000_8000: return 8'hA9;
      32'h0000_8001: return 8'h42;
      32'h0000_8002: return 8'h8D;
      32'h0000_8003: return 8'h00;
      32'h0000_8004: return 8'h02;
      32'h0000_8005: return 8'hEA;
      32'h0000_9000: return 8'h0F;
      32'h0000_9001: return 8'h12;
      32'h0000_9002: return 8'hFE;
      32'h0000_9003: return 8'hA9;
      32'h0000_9004: return 8'h55;
      32'hFFFF_FFFF: return 8'hEA;
      default:       return 8'h00;
    endcase
  endfunction

  assign mem_data = mem_rd(mem_addr);
  assign mem_ack  = mem_req && ack_en && (wcnt >= wait_cfg);

  // Cycles the current request has been waiting; restarts on every new request.
  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack || redirect)
      wcnt <= 0;
    else
      wcnt <= wcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance at least one cycle, stop when a word is offered or the budget runs out.
  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!ir_valid && cycles < limit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    ir_ready    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ack_en      = 1'b1;
    wait_cfg    = 0;
    repeat (3) @(negedge clk);

    // Cycle 0 after release: reset state
    rst = 1'b0;
    check("rst_req",    32'(mem_req),  32'h0);
    check("rst_valid",  32'(ir_valid), 32'h0);
    check("rst_ir",     ir,            32'h0);
    check("rst_ir_pc",  ir_pc,         32'h0);
    check("rst_ir_len", 32'(ir_len),   32'h0);

    // Boot sequence
    @(negedge clk);
    check("c1_req",  32'(mem_req), 32'h1);
    check("c1_addr", mem_addr,     32'h0000_FFFC);
    @(negedge clk);
    check("c2_addr", mem_addr,     32'h0000_FFFD);
    @(negedge clk);
    check("c3_req",  32'(mem_req), 32'h1);
    check("c3_addr", mem_addr,     32'h0000_8000);

    // Length decode: A9 42 / 8D 00 02 / EA
    wait_valid(10, lat);
    check("w0_lat",   32'(lat),    32'd2);
    check("w0_ir",    ir,          32'h0000_42A9);
    check("w0_len",   32'(ir_len), 32'd2);
    check("w0_pc",    ir_pc,       32'h0000_8000);
    wait_valid(10, lat);
    check("w1_lat",   32'(lat),    32'd4);
    check("w1_ir",    ir,          32'h0002_008D);
    check("w1_len",   32'(ir_len), 32'd3);
    check("w1_pc",    ir_pc,       32'h0000_8002);
    wait_valid(10, lat);
    check("w2_lat",   32'(lat),    32'd2);
    check("w2_ir",    ir,          32'h0000_00EA);
    check("w2_len",   32'(ir_len), 32'd1);
    check("w2_pc",    ir_pc,       32'h0000_8005);

    // Redirect to 9000 in the same cycle the EA word is handshaken
    redirect    = 1'b1;
    redirect_pc = 32'h0000_9000;
    @(negedge clk);
    redirect = 1'b0;
    ir_ready = 1'b0;
    check("bbr_req",   32'(mem_req),  32'h1);
    check("bbr_addr",  mem_addr,      32'h0000_9000);
    check("bbr_novld", 32'(ir_valid), 32'h0);

    // BBR 0F 12 FE, then hold with ready low
    wait_valid(10, lat);
    check("bbr_lat", 32'(lat),    32'd3);
    check("bbr_ir",  ir,          32'h00FE_120F);
    check("bbr_len", 32'(ir_len), 32'd3);
    check("bbr_pc",  ir_pc,       32'h0000_9000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(ir_valid), 32'h1);
      check("bp_ir",    ir,            32'h00FE_120F);
      check("bp_req",   32'(mem_req),  32'h0);
    end
    ir_ready = 1'b1;
    @(negedge clk);
    check("bp_next_req",  32'(mem_req), 32'h1);
    check("bp_next_addr", mem_addr,     32'h0000_9003);

    // Redirect mid-instruction while OPND1 waits
    @(negedge clk);
    check("opnd1_addr", mem_addr, 32'h0000_9004);
    ack_en      = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1234;
    @(negedge clk);
    redirect = 1'b0;
    check("rd_req",   32'(mem_req),  32'h1);
    check("rd_addr",  mem_addr,      32'h0000_1234);
    check("rd_valid", 32'(ir_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rd_hold_valid", 32'(ir_valid), 32'h0);
      check("rd_hold_addr",  mem_addr,      32'h0000_1234);
    end

    // PC wrap with two wait states on the opcode
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect = 1'b0;
    ack_en   = 1'b1;
    wait_cfg = 2;
    check("wr_addr0", mem_addr, 32'hFFFF_FFFF);
    @(negedge clk);
    check("wr_addr1",  mem_addr,      32'hFFFF_FFFF);
    check("wr_valid1", 32'(ir_valid), 32'h0);
    @(negedge clk);
    check("wr_addr2",  mem_addr,      32'hFFFF_FFFF);
    check("wr_valid2", 32'(ir_valid), 32'h0);
    @(negedge clk);
    check("wr_valid", 32'(ir_valid), 32'h1);
    check("wr_ir",    ir,            32'h0000_00EA);
    check("wr_pc",    ir_pc,         32'hFFFF_FFFF);
    check("wr_len",   32'(ir_len),   32'd1);
    @(negedge clk);
    check("wr_next_req",  32'(mem_req), 32'h1);
    check("wr_next_addr", mem_addr,     32'h0000_0000);

    // Reset mid-operation beats a pending ack and a redirect
    wait_cfg    = 0;
    rst         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_5555;
    @(negedge clk);
    check("mr_req",    32'(mem_req),  32'h0);
    check("mr_valid",  32'(ir_valid), 32'h0);
    check("mr_ir",     ir,            32'h0);
    check("mr_ir_pc",  ir_pc,         32'h0);
    check("mr_ir_len", 32'(ir_len),   32'h0);

    // Redirect held high through boot is ignored
    rst = 1'b0;
    @(negedge clk);
    check("rb_c1_addr", mem_addr, 32'h0000_FFFC);
    @(negedge clk);
    check("rb_c2_addr", mem_addr, 32'h0000_FFFD);
    @(negedge clk);
    check("rb_c3_req",  32'(mem_req), 32'h1);
    check("rb_c3_addr", mem_addr,     32'h0000_8000);
    redirect = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
